inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Instruction encoder and program loader: the inverse of the RV32I decode path.
- Accepts one instruction per beat as decoded control fields: kind, ALUOp, DMCtrl, branch condition, register indices and immediate.
- Re-encodes each beat into a 32-bit RV32I word and writes it into instruction memory at sequential word addresses.
- Used by self-checking benches and the boot path to load programs without an external assembler.

Parameters:
- AW, 12, instruction-memory byte-address width; the address counter wraps modulo 2^AW.
- MAX_WORDS, 1024, number of words that can be written per load session.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a load session; sampled only in IDLE.
- base_addr  in  AW  first byte address of the session; must be word aligned.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_last  in  1  marks the final beat of the session.
- kind  in  4  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR; all other values illegal.
- alu_op  in  4  ALUOp encoding: [2:0] maps to funct3, [3] maps to funct7[5].
- dm_ctrl  in  3  load/store width; maps to funct3.
- br_cond  in  3  branch funct3.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  sign-extended immediate (byte offset for B and J types).
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  AW  write byte address.
- im_wdata  out  32  encoded instruction word.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the session ends.
- err  out  1  sticky; cleared by start.
- err_index  out  16  word index of the first illegal or overflow beat.
- count  out  16  number of beats accepted this session.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0.
- States and transitions:
  - IDLE: on start, load address counter with base_addr, clear count and err, go to RUN. start is ignored outside IDLE.
  - RUN: in_ready=1. A beat is accepted when in_valid && in_ready. If the accepted beat has in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. Lasts one cycle, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: the word for an accepted beat appears on im_we/im_addr/im_wdata exactly one cycle after acceptance (registered).
- Throughput: one beat per cycle, with no bubbles between beats.
- After each write, the address counter advances by 4 and wraps modulo 2^AW.
- Encoding per kind:
  - R: opcode 0110011; funct3=alu_op[2:0]; funct7 = 0100000 if alu_op[3], else 0. alu_op[3] is legal only with funct3 000 or 101.
  - I-ALU: opcode 0010011; imm[11:0]. For funct3 001 or 101, the shamt is imm[4:0] and funct7[5]=alu_op[3]; alu_op[3] is legal only with funct3 101.
  - LOAD: opcode 0000011; dm_ctrl must be one of 000, 001, 010, 100, 101.
  - STORE: opcode 0100011; S-type; dm_ctrl must be one of 000, 001, 010.
  - BRANCH: opcode 1100011; B-type; br_cond must be one of 000, 001, 100, 101, 110, 111.
  - JAL: opcode 1101111; J-type.
  - JALR: opcode 1100111; funct3=000.
- Range rules (violation makes the beat illegal):
  - I- and S-type: imm in [-2048, 2047].
  - B-type: imm in [-4096, 4094] and even.
  - J-type: imm in [-2^20, 2^20-2] and even.
  - Shift: imm in [0, 31].
- Illegal beat:
  - Still written, as NOP 0x00000013.
  - Sets err; err_index latches count at the first error only.
- Overflow (count == MAX_WORDS at acceptance):
  - Beat is accepted but not written: im_we=0, address does not advance.
  - Sets err; err_index is set per the first-error rule.
  - count saturates at MAX_WORDS.
- A beat with in_last=1 ends the session even if it is illegal or overflowed.
- Reset mid-session: immediate return to IDLE with all outputs cleared. A pending write is lost.

Optional Feature:
- Macro: ENC_LUI_AUIPC_EN.
- Defined:
  - kind 7=LUI (opcode 0110111) and kind 8=AUIPC (opcode 0010111) are legal.
  - Encoded as U-type from imm[31:12].
  - A nonzero imm[11:0] makes the beat illegal.
- Undefined: kinds 7 and 8 are illegal and are written as NOP with err set.

Test Plan:
- start with base_addr=0x100, then a single beat ADD x3,x1,x2 (kind0, alu_op 0000, in_last=1) -> next cycle im_we=1, im_addr=0x100, im_wdata=0x002081B3; done pulses 2 cycles later; count=1.
- Back-to-back beats SUB x5,x6,x7; ADDI x1,x0,-1; SW x2,8(x1) -> consecutive cycles write 0x407302B3 @0x100, 0xFFF00093 @0x104, 0x0020A423 @0x108.
- BEQ x1,x2,+8 then JAL x1,+16 -> 0x00208463 and 0x010000EF.
- BRANCH with br_cond=010 as the 3rd beat -> 0x00000013 written; err=1; err_index=2; following beats encode normally.
- MAX_WORDS=4, stream 5 beats with in_last on the 5th -> 4 writes; 5th has no im_we; err=1; err_index=4; done pulses.
- rst_n low for 1 cycle mid-stream -> all outputs 0, state IDLE; a new start re-runs cleanly from base_addr.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Instruction encoder and program loader: re-encodes decoded RV32I control fields into
// instruction words and writes them to sequential IM addresses. Optional LUI/AUIPC: ENC_LUI_AUIPC_EN.
module inst_encoder_loader #(
    parameter int AW        = 12,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [3:0]    kind,
    input  logic [3:0]    alu_op,
    input  logic [2:0]    dm_ctrl,
    input  logic [2:0]    br_cond,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   err_index,
    output logic [15:0]   count,
    output logic [1:0]    dbg_state
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_count;
    logic          r_err;
    logic [15:0]   r_err_index;
    logic          r_im_we;
    logic [AW-1:0] r_im_addr;
    logic [31:0]   r_im_wdata;
    logic          r_done;

    logic          w_fit12;
    logic          w_fit13;
    logic          w_fit21;
    logic          w_shamt_ok;
    logic [31:0]   w_enc;
    logic          w_bad;
    logic [31:0]   w_word;
    logic          w_overflow;
    logic          w_accept;

    // Immediate range checks: the bits above the field must all equal its sign bit.
    assign w_fit12    = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign w_fit13    = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    assign w_fit21    = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
    assign w_shamt_ok = (imm[31:5] == '0);

    always_comb begin
        w_enc = NOP;
        w_bad = 1'b0;
        case (kind)
            4'd0: begin
                w_enc = {1'b0, alu_op[3], 5'b0, rs2, rs1, alu_op[2:0], rd, 7'b0110011};
                w_bad = alu_op[3] && !((alu_op[2:0] == 3'b000) || (alu_op[2:0] == 3'b101));
            end
            4'd1: begin
                if (alu_op[1:0] == 2'b01) begin
                    // funct3 001/101 are the shifts: shamt in imm[4:0], funct7[5] from alu_op[3]
                    w_enc = {1'b0, alu_op[3], 5'b0, imm[4:0], rs1, alu_op[2:0], rd, 7'b0010011};
                    w_bad = !w_shamt_ok || (alu_op[3] && (alu_op[2:0] != 3'b101));
                end else begin
                    w_enc = {imm[11:0], rs1, alu_op[2:0], rd, 7'b0010011};
                    w_bad = !w_fit12 || alu_op[3];
                end
            end
            4'd2: begin
                w_enc = {imm[11:0], rs1, dm_ctrl, rd, 7'b0000011};
                w_bad = !w_fit12 || (dm_ctrl == 3'b011) || (dm_ctrl[2:1] == 2'b11);
            end
            4'd3: begin
                w_enc = {imm[11:5], rs2, rs1, dm_ctrl, imm[4:0], 7'b0100011};
                w_bad = !w_fit12 || dm_ctrl[2] || (dm_ctrl == 3'b011);
            end
            4'd4: begin
                w_enc = {imm[12], imm[10:5], rs2, rs1, br_cond, imm[4:1], imm[11], 7'b1100011};
                w_bad = !w_fit13 || (br_cond[2:1] == 2'b01);
            end
            4'd5: begin
                w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                w_bad = !w_fit21;
            end
            4'd6: begin
                w_enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                w_bad = !w_fit12;
            end
`ifdef ENC_LUI_AUIPC_EN
            4'd7: begin
                w_enc = {imm[31:12], rd, 7'b0110111};
                w_bad = (imm[11:0] != 12'h000);
            end
            4'd8: begin
                w_enc = {imm[31:12], rd, 7'b0010111};
                w_bad = (imm[11:0] != 12'h000);
            end
`endif
            default: begin
                w_enc = NOP;
                w_bad = 1'b1;
            end
        endcase
    end

    assign w_word     = w_bad ? NOP : w_enc;
    assign w_overflow = (r_count == 16'(MAX_WORDS));
    // in_valid/in_ready: a beat transfers on a rising edge where both are high; in_ready depends only on state.
    assign w_accept   = in_valid && (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_index <= '0;
            r_im_we     <= 1'b0;
            r_im_addr   <= '0;
            r_im_wdata  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_im_we <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= {base_addr[AW-1:2], 2'b00};
                        r_count     <= '0;
                        r_err       <= 1'b0;
                        r_err_index <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (!w_overflow) begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= r_addr;
                            r_im_wdata <= w_word;
                            r_addr     <= r_addr + AW'(4);
                            r_count    <= r_count + 16'd1;
                        end
                        if (w_overflow || w_bad) begin
                            r_err <= 1'b1;
                            if (!r_err) r_err_index <= r_count;
                        end
                        if (in_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = r_done;
    assign im_we     = r_im_we;
    assign im_addr   = r_im_addr;
    assign im_wdata  = r_im_wdata;
    assign err       = r_err;
    assign err_index = r_err_index;
    assign count     = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: expected {address, word} pairs are queued
// when beats are driven and compared when the DUT raises im_we.
module tb_inst_encoder_loader;

  localparam int AW = 12;
  localparam int MW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [3:0]    kind;
  logic [3:0]    alu_op;
  logic [2:0]    dm_ctrl;
  logic [2:0]    br_cond;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   imm;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   err_index;
  logic [15:0]   count;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_fail;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  logic [AW-1:0]  exp_addr;

  inst_encoder_loader #(.AW(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .kind(kind), .alu_op(alu_op), .dm_ctrl(dm_ctrl), .br_cond(br_cond),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .err(err), .err_index(err_index),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", im_addr, im_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({im_addr, im_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   im_addr, im_wdata, mon_exp[AW+31:32], mon_exp[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] enc_addi(input logic [11:0] i12, input logic [4:0] s1, input logic [4:0] d);
    return {i12, s1, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic b30, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {1'b0, b30, 5'b0, s2, s1, f3, d, 7'b0110011};
  endfunction

  // driver tasks
  task automatic start_session(input logic [AW-1:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    exp_addr = base;
    n_checks++;
    if ({in_ready, busy, err, count} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL start: got ready=%b busy=%b err=%b count=%0d, required 1 1 0 0",
               in_ready, busy, err, count);
    end
  endtask

  task automatic send(input logic [3:0] k, input logic [3:0] aop, input logic [2:0] dm,
                      input logic [2:0] br, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic lst,
                      input logic [31:0] exp_word, input logic exp_we);
    @(negedge clk);
    kind = k; alu_op = aop; dm_ctrl = dm; br_cond = br;
    rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = lst; in_valid = 1'b1;
    if (exp_we) begin
      exp_q.push_back({exp_addr, exp_word});
      exp_addr = exp_addr + AW'(4);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic finish_session(input logic [15:0] exp_count, input logic exp_err, input logic [15:0] exp_idx);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    n_checks++;
    if ({busy, in_ready, done, dbg_state} !== {1'b1, 1'b0, 1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL drain: got busy=%b ready=%b done=%b state=%0d, required 1 0 0 2",
               busy, in_ready, done, dbg_state);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b, required 1 0", done, busy);
    end
    n_checks++;
    if ({count, err, err_index} !== {exp_count, exp_err, exp_idx}) begin
      n_fail++;
      $display("FAIL status: got count=%0d err=%b err_index=%0d, required %0d %b %0d",
               count, err, err_index, exp_count, exp_err, exp_idx);
    end
    @(negedge clk);
    n_checks++;
    if ({done, dbg_state} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL done_end: got done=%b state=%0d, required 0 0", done, dbg_state);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({in_ready, im_we, im_addr, im_wdata, busy, done, err, err_index, count, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL %s: got ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b idx=%0d count=%0d state=%0d, required all 0",
               name, in_ready, im_we, im_addr, im_wdata, busy, done, err, err_index, count, dbg_state);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    kind = '0; alu_op = '0; dm_ctrl = '0; br_cond = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_single_add();
    start_session(12'h100);
    send(4'd0, 4'b0000, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b1);
    finish_session(16'd1, 1'b0, 16'd0);
  endtask

  task automatic test_back_to_back();
    start_session(12'h100);
    send(4'd0, 4'b1000, 3'd0, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h407302B3, 1'b1);
    send(4'd1, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b1);
    send(4'd3, 4'b0000, 3'd2, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423, 1'b1);
    finish_session(16'd3, 1'b0, 16'd0);
  endtask

  task automatic test_branch_jal();
    start_session(12'h040);
    send(4'd4, 4'b0000, 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00208463, 1'b1);
    send(4'd5, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h010000EF, 1'b1);
    finish_session(16'd2, 1'b0, 16'd0);
  endtask

  task automatic test_illegal_branch();
    start_session(12'h200);
    send(4'd0, 4'b0000, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 1'b1);
    send(4'd0, 4'b1000, 3'd0, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h407302B3, 1'b1);
    send(4'd4, 4'b0000, 3'd0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00000013, 1'b1);
    send(4'd6, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd5, 5'd0, 32'd4, 1'b1, 32'h004280E7, 1'b1);
    finish_session(16'd4, 1'b1, 16'd2);
  endtask

  task automatic test_ranges();
    logic [31:0] w_kind7;
    // I-type bounds and shamt bound
    start_session(12'h000);
    send(4'd1, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b0, 32'h7FF00093, 1'b1);
    send(4'd1, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h00000013, 1'b1);
    send(4'd1, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b0, 32'h80000093, 1'b1);
    send(4'd1, 4'b0001, 3'd0, 3'd0, 5'd1, 5'd2, 5'd0, 32'd32, 1'b1, 32'h00000013, 1'b1);
    finish_session(16'd4, 1'b1, 16'd1);
    // branch / jal bounds, kind 7
`ifdef ENC_LUI_AUIPC_EN
    w_kind7 = 32'h123450B7;
`else
    w_kind7 = 32'h00000013;
`endif
    start_session(12'h000);
    send(4'd4, 4'b0000, 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b0, 32'h7E208FE3, 1'b1);
    send(4'd4, 4'b0000, 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4095, 1'b0, 32'h00000013, 1'b1);
    send(4'd5, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1048574, 1'b0, 32'h7FFFF0EF, 1'b1);
    send(4'd7, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1, w_kind7, 1'b1);
    finish_session(16'd4, 1'b1, 16'd1);
    // shift / load / store widths
    start_session(12'h080);
    send(4'd1, 4'b1101, 3'd0, 3'd0, 5'd5, 5'd6, 5'd0, 32'd31, 1'b0, 32'h41F35293, 1'b1);
    send(4'd2, 4'b0000, 3'b010, 3'd0, 5'd4, 5'd3, 5'd0, -32'sd4, 1'b0, 32'hFFC1A203, 1'b1);
    send(4'd2, 4'b0000, 3'b011, 3'd0, 5'd4, 5'd3, 5'd0, 32'd0, 1'b0, 32'h00000013, 1'b1);
    send(4'd3, 4'b0000, 3'b000, 3'd0, 5'd0, 5'd8, 5'd7, -32'sd1, 1'b1, 32'hFE740FA3, 1'b1);
    finish_session(16'd4, 1'b1, 16'd2);
  endtask

  task automatic test_overflow();
    logic [11:0] i12;
    start_session(12'h000);
    for (int i = 0; i < 5; i++) begin
      i12 = 12'($urandom_range(0, 4095));
      send(4'd1, 4'b0000, 3'd0, 3'd0, 5'd2, 5'd1, 5'd0, {{20{i12[11]}}, i12}, (i == 4),
           enc_addi(i12, 5'd1, 5'd2), (i < 4));
    end
    finish_session(16'd4, 1'b1, 16'd4);
  endtask

  task automatic test_random_wrap();
    logic [11:0] i12;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic        b30;
    for (int s = 0; s < 3; s++) begin
      start_session(12'hFF8);
      for (int i = 0; i < 4; i++) begin
        d  = 5'($urandom_range(0, 31));
        s1 = 5'($urandom_range(0, 31));
        s2 = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) begin
          i12 = 12'($urandom_range(0, 4095));
          send(4'd1, 4'b0100, 3'd0, 3'd0, d, s1, s2, {{20{i12[11]}}, i12}, (i == 3),
               {i12, s1, 3'b100, d, 7'b0010011}, 1'b1);
        end else begin
          f3  = 3'($urandom_range(0, 7));
          b30 = ((f3 == 3'd0) || (f3 == 3'd5)) ? 1'($urandom_range(0, 1)) : 1'b0;
          send(4'd0, {b30, f3}, 3'd0, 3'd0, d, s1, s2, 32'd0, (i == 3),
               enc_r(b30, s2, s1, f3, d), 1'b1);
        end
      end
      finish_session(16'd4, 1'b0, 16'd0);
    end
  endtask

  task automatic test_reset_midstream();
    start_session(12'h300);
    send(4'd0, 4'b0000, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 1'b1);
    @(negedge clk);
    kind = 4'd0; rd = 5'd9; in_last = 1'b1; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midstream_reset");
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_pending: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check_all_zero("idle_after_midstream");
    start_session(12'h300);
    send(4'd0, 4'b0000, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b1);
    finish_session(16'd1, 1'b0, 16'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_addr = '0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_branch_jal();
    test_illegal_branch();
    test_ranges();
    test_overflow();
    test_random_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
